pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 124 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: memory and MDU stalls, branch flush,
// load-use interlock, saturating performance counters and a sticky memory-timeout flag.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_branch_taken,
    input  logic             mdu_start,
    input  logic             mdu_done,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             err_timeout
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, MDU_WAIT} state_t;

    state_t      state;
    logic [15:0] wait_cnt;
    logic        mem_pend, mdu_pend, lu_hit;
    logic        mem_stall, mdu_stall, br_flush, load_use;

    assign mem_pend = mem_req && !mem_ack;
    assign mdu_pend = mdu_start && !mdu_done;
    assign lu_hit   = ex_is_load && (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Event decode with RUN priority: memory > MDU > branch > load-use.
    always_comb begin
        mem_stall = 1'b0;
        mdu_stall = 1'b0;
        br_flush  = 1'b0;
        load_use  = 1'b0;
        case (state)
            RUN: begin
                mem_stall = mem_pend;
                mdu_stall = !mem_pend && mdu_pend;
                br_flush  = !mem_pend && !mdu_pend && ex_branch_taken;
                load_use  = !mem_pend && !mdu_pend && !ex_branch_taken && lu_hit;
            end
            MEM_WAIT: mem_stall = !mem_ack;
            MDU_WAIT: mdu_stall = !mdu_done;
            default: ;
        endcase
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!reset) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if (mem_stall) begin
            {pc_en, ifid_en, idex_en, exmem_en} = '0;
            memwb_flush = 1'b1;
        end else if (mdu_stall) begin
            {pc_en, ifid_en, idex_en} = '0;
            // A pending memory access while the MDU spins freezes EX/MEM instead of bubbling it.
            if (mem_pend) begin
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end else begin
                exmem_flush = 1'b1;
            end
        end else if (br_flush) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            err_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            case (state)
                RUN:      if (mem_pend) state <= MEM_WAIT;
                          else if (mdu_pend) state <= MDU_WAIT;
                MEM_WAIT: if (mem_ack) state <= RUN;
                MDU_WAIT: if (mdu_done) state <= RUN;
                default:  state <= RUN;
            endcase

            if (state == MEM_WAIT) begin
                if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
                if (({1'b0, wait_cnt} + 17'd1) >= 17'(MEM_TIMEOUT)) err_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (!pc_en && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if (br_flush && (flush_count != '1)) flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: rule-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_pipeline_ctrl;
    localparam int CNT_W = 4;
    localparam int TO    = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0, reset = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic ex_is_load = 0, ex_branch_taken = 0, mdu_start = 0, mdu_done = 0, mem_req = 0, mem_ack = 0;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic err_timeout;

    int total = 0, bad = 0;

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_branch_taken(ex_branch_taken),
        .mdu_start(mdu_start), .mdu_done(mdu_done), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .stall_cycles(stall_cycles), .flush_count(flush_count),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: what the pipeline is waiting on, plus counters.
    typedef enum {W_NONE, W_MEM, W_MDU} wait_t;
    wait_t waiting;
    int m_stall, m_flush, m_memcyc;
    bit m_err;

    // Returns {branch_flush, pc,ifid,idex,exmem,memwb en, ifid,idex,exmem,memwb flush}.
    function automatic logic [9:0] model_out();
        logic [4:0] en; logic [3:0] fl; logic br;
        bit mem_open, mdu_open, hazard;
        en = 5'b11111; fl = 4'b0000; br = 1'b0;
        mem_open = mem_req && !mem_ack;
        mdu_open = mdu_start && !mdu_done;
        hazard = ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        if (!reset) en = 5'b00000;
        else if ((waiting == W_NONE && mem_open) || (waiting == W_MEM && !mem_ack)) begin
            en = 5'b00001; fl = 4'b0001;
        end else if ((waiting == W_NONE && mdu_open) || (waiting == W_MDU && !mdu_done)) begin
            if (waiting == W_MDU && mem_open) begin en = 5'b00001; fl = 4'b0001; end
            else begin en = 5'b00011; fl = 4'b0010; end
        end else if (waiting == W_NONE && ex_branch_taken) begin
            fl = 4'b1100; br = 1'b1;
        end else if (waiting == W_NONE && hazard) begin
            en = 5'b00111; fl = 4'b0100;
        end
        return {br, en, fl};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            waiting <= W_NONE; m_stall <= 0; m_flush <= 0; m_memcyc <= 0; m_err <= 0;
        end else begin
            logic [9:0] o;
            o = model_out();
            if (!o[8]) m_stall <= (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (o[9])  m_flush <= (m_flush < CMAX) ? m_flush + 1 : CMAX;
            if (waiting == W_MEM) begin
                m_memcyc <= m_memcyc + 1;
                if (m_memcyc + 1 >= TO) m_err <= 1;
            end else m_memcyc <= 0;
            if (waiting == W_NONE) begin
                if (mem_req && !mem_ack) waiting <= W_MEM;
                else if (mdu_start && !mdu_done) waiting <= W_MDU;
            end else if (waiting == W_MEM && mem_ack) waiting <= W_NONE;
            else if (waiting == W_MDU && mdu_done) waiting <= W_NONE;
        end
    end

    always @(negedge clk) begin
        logic [9:0] o;
        o = model_out();
        chk("ctl_outputs", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                            ifid_flush, idex_flush, exmem_flush, memwb_flush}, o[8:0]);
        chk("stall_cycles", stall_cycles, m_stall);
        chk("flush_count", flush_count, m_flush);
        chk("err_timeout", err_timeout, m_err);
    end

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_is_load = 0; ex_branch_taken = 0;
        mdu_start = 0; mdu_done = 0; mem_req = 0; mem_ack = 0;
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        @(negedge clk); @(negedge clk);
        chk("rst_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
        chk("rst_cnt", {stall_cycles, flush_count, err_timeout}, 0);
        @(posedge clk); #1 reset = 1;
    endtask

    initial begin
        do_reset();

        // Load-use on rs2, then the same with ex_rd=0.
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; id_rs1 = 3;
        @(negedge clk);
        chk("lu_stall", {pc_en, ifid_en, idex_flush}, 3'b001);
        step();
        chk("lu_cnt", stall_cycles, 1);
        ex_rd = 0; id_rs2 = 0;
        @(negedge clk);
        chk("lu_rd0", {pc_en, ifid_en, idex_flush}, 3'b110);
        step(); idle(); step();
        chk("lu_rd0_cnt", stall_cycles, 1);

        // Branch and load-use together: branch wins.
        do_reset();
        ex_branch_taken = 1; ex_is_load = 1; ex_rd = 7; id_rs1 = 7;
        @(negedge clk);
        chk("br_lu", {ifid_flush, idex_flush, pc_en}, 3'b111);
        step(); idle();
        chk("br_lu_cnt", {flush_count, stall_cycles}, {4'd1, 4'd0});

        // Memory stall for 3 cycles, then ack; branch held high is ignored throughout.
        do_reset();
        mem_req = 1; ex_branch_taken = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mem_freeze", {pc_en, exmem_en, memwb_flush, ifid_flush}, 4'b0010);
            step();
        end
        mem_ack = 1;
        @(negedge clk);
        chk("mem_release", {pc_en, exmem_en, memwb_flush, ifid_flush}, 4'b1100);
        step(); idle();
        chk("mem_cnt", {stall_cycles, flush_count}, {4'd3, 4'd0});
        mem_req = 1; mem_ack = 1;
        @(negedge clk);
        chk("mem_same_cycle", pc_en, 1);
        step(); idle(); step();

        // MDU busy for 4 cycles, then done; then start+done together.
        do_reset();
        mdu_start = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mdu_wait", {pc_en, exmem_flush, memwb_en}, 3'b011);
            step();
        end
        mdu_done = 1;
        @(negedge clk);
        chk("mdu_done", {pc_en, exmem_flush}, 2'b10);
        step();
        chk("mdu_cnt", stall_cycles, 4);
        @(negedge clk);
        chk("mdu_same_cycle", pc_en, 1);
        step(); idle(); step();
        chk("mdu_same_cnt", stall_cycles, 4);

        // MDU wait overlapped with a pending memory access.
        mdu_start = 1; step();
        mem_req = 1;
        @(negedge clk);
        chk("mdu_mem", {exmem_en, exmem_flush, memwb_flush}, 3'b001);
        step(); mem_ack = 1;
        @(negedge clk);
        chk("mdu_mem_ack", {exmem_en, exmem_flush, memwb_flush}, 3'b110);
        step(); idle(); mdu_done = 1; step(); idle(); step();

        // Timeout: ack never comes; counter saturates; async reset abandons the stall.
        do_reset();
        mem_req = 1;
        step(8);
        chk("to_before", err_timeout, 0);
        step();
        chk("to_set", err_timeout, 1);
        step(11);
        chk("to_held", err_timeout, 1);
        chk("stall_sat", stall_cycles, CMAX);
        #2 reset = 0;
        #1;
        chk("async_rst_err", err_timeout, 0);
        chk("async_rst_en", {pc_en, ifid_en, idex_en, exmem_en, memwb_en}, 0);
        @(posedge clk); #1 reset = 1; idle();
        @(negedge clk);
        chk("post_rst_run", {pc_en, memwb_flush}, 2'b10);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
